// File: rtl/in_channel_feeder.sv
// Purpose : host-to-core input channel; circular word buffer with count reported as inSize.
// Latency : a pop requested at edge N shows inData/inValid after edge N; a push is visible in inSize after its edge.
// Backpress: hostReady drops while NIn words are buffered. The host holds its word until it is accepted.
//
// Ports
//   clock, reset             single clock; asynchronous active-high reset
//   hostValid/hostData       host offers a word; it is accepted when hostReady is high
//   hostReady                count < NIn (driven by the registered count only)
//   inRequest                core `in` instruction; pops one word if any are buffered
//   inData/inValid           popped word (held between pops); inValid pulses for one cycle
//   inSize                   registered word count
//   underflows               count of pops attempted while empty
//                            (enabled only when IN_UNDERFLOW_COUNT_EN is defined, otherwise 0)
//
// Optional feature macro: IN_UNDERFLOW_COUNT_EN
module in_channel_feeder #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 16,
    localparam int CW                = $clog2(NIn + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          hostValid,
    input  logic [MemoryElementWidth-1:0] hostData,
    output logic                          hostReady,
    input  logic                          inRequest,
    output logic [MemoryElementWidth-1:0] inData,
    output logic                          inValid,
    output logic [CW-1:0]                 inSize,
    output logic [15:0]                   underflows
);

    localparam int PW = (NIn > 1) ? $clog2(NIn) : 1;

    logic [MemoryElementWidth-1:0] r_mem [NIn];
    logic [PW-1:0]                 r_wr_ptr;
    logic [PW-1:0]                 r_rd_ptr;
    logic [CW-1:0]                 r_count;
    logic [MemoryElementWidth-1:0] r_in_data;
    logic                          r_in_valid;

    logic w_push;
    logic w_pop;
    logic w_empty;

    assign w_empty   = (r_count == '0);
    assign hostReady = (r_count < CW'(NIn));
    // Each side sees only the registered count. A full buffer therefore refuses
    // a push even when a pop happens in the same cycle. An empty buffer fails a
    // pop even when a push happens in the same cycle.
    assign w_push    = hostValid && hostReady;
    assign w_pop     = inRequest && !w_empty;

    assign inData    = r_in_data;
    assign inValid   = r_in_valid;
    assign inSize    = r_count;

    // The storage array has no reset. A word is read only after a push has
    // written it, so its reset value is never observed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= hostData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_data  <= '0;
            r_in_valid <= 1'b0;
        end else begin
            // Depth need not be a power of two, so wrap by explicit compare.
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(NIn - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= (r_rd_ptr == PW'(NIn - 1)) ? '0 : r_rd_ptr + PW'(1);
                r_in_data <= r_mem[r_rd_ptr];
            end
            r_in_valid <= w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IN_UNDERFLOW_COUNT_EN
    logic [15:0] r_underflows;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_underflows <= '0;
        end else if (inRequest && w_empty && (r_underflows != 16'hFFFF)) begin
            r_underflows <= r_underflows + 16'd1;
        end
    end

    assign underflows = r_underflows;
`else
    assign underflows = 16'd0;
`endif

endmodule
